// File: rtl/phase_demand_arbiter_if.sv
// ---------------------------------------------------------------------------
// phase_demand_arbiter_if
//   Handshake between the phase demand arbiter and the intersection
//   controller FSM.
//
//   Signals
//     current_phase     2  phase now active (0 SS straight, 1 SS turn,
//                          2 CS straight, 3 CS turn), driven by the controller
//     phase_done        1  one-cycle pulse at the end of the current phase
//     next_phase        2  phase offered by the arbiter, stable while valid
//     next_phase_valid  1  offer valid, held until accepted
//     next_phase_ack    1  controller accepts the offer (valid & ack)
//
//   Modports
//     master  controller side
//     slave   arbiter side
// ---------------------------------------------------------------------------
interface phase_demand_arbiter_if;
    logic [1:0] current_phase;
    logic       phase_done;
    logic [1:0] next_phase;
    logic       next_phase_valid;
    logic       next_phase_ack;

    modport master (
        output current_phase,
        output phase_done,
        output next_phase_ack,
        input  next_phase,
        input  next_phase_valid
    );

    modport slave (
        input  current_phase,
        input  phase_done,
        input  next_phase_ack,
        output next_phase,
        output next_phase_valid
    );
endinterface

// File: rtl/phase_demand_arbiter.sv
// ---------------------------------------------------------------------------
// phase_demand_arbiter
//   Conditions the pedestrian-button and car-sensor inputs, latches them as
//   per-phase demands and, at each phase end, offers the next phase to the
//   intersection controller. Selection is round-robin over pending demands
//   with a starvation override. Also raises a speed-up request when the
//   active phase has no demand while another phase is waiting.
//
//   Parameters
//     DEBOUNCE_CYCLES  stable cycles before an input level is accepted
//     TICK_CYCLES      clk cycles per one-second tick
//     WAIT_LIMIT_S     seconds a demand may wait before it is starved
//
//   Ports
//     clk                                        in   system clock (1 kHz)
//     reset_n                                    in   synchronous, active low
//     i_straight_street_pedestrian_button        in   demand on phase 0
//     i_cross_street_pedestrian_button           in   demand on phase 2
//     i_straight_street_straight_lane_car_sensor in   demand on phase 0
//     i_straight_street_turn_lane_car_sensor     in   demand on phase 1
//     i_cross_street_straight_lane_car_sensor    in   demand on phase 2
//     i_cross_street_turn_lane_car_sensor        in   demand on phase 3
//     ctl_if                                     --   controller handshake
//     o_demand_pending                           out  latched demand per phase
//     o_speed_up_req                             out  shorten current phase
//     o_starvation_alarm                         out  some phase is starved
//
//   FSM states
//     state  | meaning
//     IDLE   | waiting for phase_done from the controller
//     DECIDE | one cycle: pick and register next_phase
//     OFFER  | next_phase_valid high, waiting for next_phase_ack
// ---------------------------------------------------------------------------
module phase_demand_arbiter #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int TICK_CYCLES     = 1000,
    parameter int WAIT_LIMIT_S    = 180
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_straight_street_pedestrian_button,
    input  logic                    i_cross_street_pedestrian_button,
    input  logic                    i_straight_street_straight_lane_car_sensor,
    input  logic                    i_straight_street_turn_lane_car_sensor,
    input  logic                    i_cross_street_straight_lane_car_sensor,
    input  logic                    i_cross_street_turn_lane_car_sensor,
    phase_demand_arbiter_if.slave   ctl_if,
    output logic [3:0]              o_demand_pending,
    output logic                    o_speed_up_req,
    output logic                    o_starvation_alarm
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TICK_CYCLES + 1);
    localparam int WW = $clog2(WAIT_LIMIT_S + 1);
    localparam int NIN = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECIDE = 2'd1,
        ST_OFFER  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Input conditioning
    // Index map: 0 SS ped button, 1 CS ped button, 2 SS straight sensor,
    //            3 SS turn sensor, 4 CS straight sensor, 5 CS turn sensor.
    // -----------------------------------------------------------------------
    logic [NIN-1:0] w_raw;
    logic [NIN-1:0] r_sync1;
    logic [NIN-1:0] r_sync2;
    logic [NIN-1:0] r_deb;
    logic [DW-1:0]  r_db_cnt [NIN];
    logic [NIN-1:0] w_db_hit;
    logic [NIN-1:0] w_deb_next;

    assign w_raw = {i_cross_street_turn_lane_car_sensor,
                    i_cross_street_straight_lane_car_sensor,
                    i_straight_street_turn_lane_car_sensor,
                    i_straight_street_straight_lane_car_sensor,
                    i_cross_street_pedestrian_button,
                    i_straight_street_pedestrian_button};

    // The counter only runs while the synced level differs from the accepted
    // level; a change back to the accepted level clears it. The debounced
    // level is taken on the edge where the counter reaches DEBOUNCE_CYCLES,
    // and the counter restarts from 0 so it can never run past that value.
    always_comb begin
        w_db_hit   = '0;
        w_deb_next = r_deb;
        for (int i = 0; i < NIN; i++) begin
            w_db_hit[i]   = (r_sync2[i] != r_deb[i]) &&
                            (r_db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1));
            w_deb_next[i] = w_db_hit[i] ? r_sync2[i] : r_deb[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            for (int i = 0; i < NIN; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb   <= w_deb_next;
            for (int i = 0; i < NIN; i++) begin
                if ((r_sync2[i] == r_deb[i]) || w_db_hit[i]) begin
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Demand latch
    // Set terms look at the debounced level as it is being accepted, so the
    // demand bit rises on the same edge as the debounced level.
    // -----------------------------------------------------------------------
    state_t         r_state;
    state_t         w_state_next;
    logic           w_valid;
    logic           w_load;
    logic           w_xfer;
    logic [1:0]     r_next_phase;
    logic [1:0]     w_sel;
    logic [3:0]     r_dem;
    logic [1:0]     w_btn_rise;
    logic [3:0]     w_dem_set;
    logic [3:0]     w_dem_clr;

    assign w_btn_rise = w_deb_next[1:0] & ~r_deb[1:0];
    assign w_dem_set  = {w_deb_next[5],
                         w_btn_rise[1] | w_deb_next[4],
                         w_deb_next[3],
                         w_btn_rise[0] | w_deb_next[2]};
    assign w_xfer     = w_valid & ctl_if.next_phase_ack;
    assign w_dem_clr  = w_xfer ? (4'b0001 << r_next_phase) : 4'b0000;

    // Set is applied after clear so a same-cycle set keeps the bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_dem <= '0;
        end else begin
            r_dem <= (r_dem & ~w_dem_clr) | w_dem_set;
        end
    end

    // -----------------------------------------------------------------------
    // One-second tick and per-phase wait counters
    // -----------------------------------------------------------------------
    logic [TW-1:0] r_tick_cnt;
    logic          w_tick;
    logic [WW-1:0] r_wait [4];
    logic [3:0]    w_starved;
    logic          r_alarm;

    assign w_tick = (r_tick_cnt == TW'(TICK_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    always_comb begin
        w_starved = '0;
        for (int p = 0; p < 4; p++) begin
            w_starved[p] = (r_wait[p] == WW'(WAIT_LIMIT_S));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int p = 0; p < 4; p++) begin
                r_wait[p] <= '0;
            end
            r_alarm <= 1'b0;
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (!r_dem[p]) begin
                    r_wait[p] <= '0;
                end else if (w_tick && !w_starved[p]) begin
                    r_wait[p] <= r_wait[p] + WW'(1);
                end
            end
            r_alarm <= |w_starved;
        end
    end

    // -----------------------------------------------------------------------
    // Next-phase selection: starved phase first (lowest index), then the
    // first pending phase after current_phase, else simply the following one.
    // The rotating scan runs from the far end so the nearest hit wins.
    // -----------------------------------------------------------------------
    logic       w_star_found;
    logic [1:0] w_star_idx;
    logic       w_rr_found;
    logic [1:0] w_rr_idx;
    logic [1:0] w_scan;

    always_comb begin
        w_star_found = 1'b0;
        w_star_idx   = '0;
        w_rr_found   = 1'b0;
        w_rr_idx     = '0;
        w_scan       = '0;
        for (int p = 3; p >= 0; p--) begin
            if (w_starved[p]) begin
                w_star_found = 1'b1;
                w_star_idx   = 2'(p);
            end
        end
        for (int k = 4; k >= 1; k--) begin
            w_scan = ctl_if.current_phase + 2'(k);
            if (r_dem[w_scan]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_scan;
            end
        end
        if (w_star_found) begin
            w_sel = w_star_idx;
        end else if (w_rr_found) begin
            w_sel = w_rr_idx;
        end else begin
            w_sel = ctl_if.current_phase + 2'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Offer FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_valid      = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ctl_if.phase_done) begin
                    w_state_next = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                w_load       = 1'b1;
                w_state_next = ST_OFFER;
            end
            ST_OFFER: begin
                w_valid = 1'b1;
                if (ctl_if.next_phase_ack) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_next_phase <= '0;
        end else if (w_load) begin
            r_next_phase <= w_sel;
        end
    end

    // -----------------------------------------------------------------------
    // Speed-up request: only while idle, current phase has nothing waiting
    // and at least one other phase does.
    // -----------------------------------------------------------------------
    logic [3:0] w_cur_mask;
    logic       r_speed;

    assign w_cur_mask = 4'b0001 << ctl_if.current_phase;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_speed <= 1'b0;
        end else begin
            r_speed <= (r_state == ST_IDLE) &&
                       !(|(r_dem & w_cur_mask)) &&
                       (|(r_dem & ~w_cur_mask));
        end
    end

    assign ctl_if.next_phase       = r_next_phase;
    assign ctl_if.next_phase_valid = w_valid;
    assign o_demand_pending        = r_dem;
    assign o_speed_up_req          = r_speed;
    assign o_starvation_alarm      = r_alarm;

endmodule

// File: tb/tb_phase_demand_arbiter.sv
module tb_phase_demand_arbiter;

    localparam int DEB  = 20;
    localparam int TICK = 20;
    localparam int WLIM = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ss_ped = 1'b0;
    logic       cs_ped = 1'b0;
    logic       ss_str = 1'b0;
    logic       ss_trn = 1'b0;
    logic       cs_str = 1'b0;
    logic       cs_trn = 1'b0;
    logic [3:0] dem;
    logic       spd;
    logic       alarm;

    int total = 0;
    int bad   = 0;

    phase_demand_arbiter_if u_if ();

    phase_demand_arbiter #(
        .DEBOUNCE_CYCLES(DEB),
        .TICK_CYCLES(TICK),
        .WAIT_LIMIT_S(WLIM)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .i_straight_street_pedestrian_button(ss_ped),
        .i_cross_street_pedestrian_button(cs_ped),
        .i_straight_street_straight_lane_car_sensor(ss_str),
        .i_straight_street_turn_lane_car_sensor(ss_trn),
        .i_cross_street_straight_lane_car_sensor(cs_str),
        .i_cross_street_turn_lane_car_sensor(cs_trn),
        .ctl_if(u_if),
        .o_demand_pending(dem),
        .o_speed_up_req(spd),
        .o_starvation_alarm(alarm)
    );

    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    logic [DEB+1:0] m_hist [6];
    logic [5:0]     m_deb;
    logic [3:0]     m_dem;
    int             m_wait [4];
    int             m_cyc;
    logic           m_alarm;
    logic           m_spd;
    logic           m_dec;
    logic           m_off;
    logic [1:0]     m_np;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_idle();
        ss_ped = 0; cs_ped = 0; ss_str = 0; ss_trn = 0; cs_str = 0; cs_trn = 0;
        u_if.current_phase  = 2'd0;
        u_if.phase_done     = 1'b0;
        u_if.next_phase_ack = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset_n = 1'b0;
        cyc(3);
        reset_n = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_hist[i] = '0;
        for (int p = 0; p < 4; p++) m_wait[p] = 0;
        m_deb = '0; m_dem = '0; m_cyc = 0; m_alarm = 0; m_spd = 0;
        m_dec = 0; m_off = 0; m_np = '0;
    endtask

    // One clock edge of the arbiter as described by its rules: a level is
    // accepted once the pin has shown it for DEB consecutive samples that
    // have made it through the two-stage synchronizer.
    task automatic model_step(input logic [5:0] pins, input logic [1:0] cp,
                              input logic pd, input logic ack);
        logic [5:0]     dn;
        logic [5:0]     rise;
        logic [3:0]     set;
        logic [3:0]     clr;
        logic [3:0]     starved;
        logic [DEB-1:0] win;
        logic           tick;
        logic           idle;
        logic           found;
        logic [1:0]     sel;
        int             q;
        for (int i = 0; i < 6; i++) begin
            m_hist[i] = {m_hist[i][DEB:0], pins[i]};
            win = m_hist[i][DEB+1:2];
            if (win == '1)      dn[i] = 1'b1;
            else if (win == '0) dn[i] = 1'b0;
            else                dn[i] = m_deb[i];
        end
        rise = dn & ~m_deb;
        set  = {dn[5], rise[1] | dn[4], dn[3], rise[0] | dn[2]};
        clr  = (m_off && ack) ? 4'(1 << m_np) : 4'b0000;
        tick = ((m_cyc % TICK) == TICK - 1);
        for (int p = 0; p < 4; p++) starved[p] = (m_wait[p] == WLIM);
        found = 0;
        sel = 2'd0;
        for (int p = 0; p < 4; p++) begin
            if (!found && starved[p]) begin sel = 2'(p); found = 1; end
        end
        for (int d = 1; d <= 4; d++) begin
            q = (int'(cp) + d) % 4;
            if (!found && m_dem[q]) begin sel = 2'(q); found = 1; end
        end
        if (!found) sel = 2'((int'(cp) + 1) % 4);
        idle    = !m_dec && !m_off;
        m_spd   = idle && !m_dem[cp] && ((m_dem & ~4'(1 << cp)) != 4'b0000);
        m_alarm = |starved;
        for (int p = 0; p < 4; p++) begin
            if (!m_dem[p]) m_wait[p] = 0;
            else if (tick && m_wait[p] < WLIM) m_wait[p] = m_wait[p] + 1;
        end
        if (m_dec) begin
            m_np = sel; m_off = 1; m_dec = 0;
        end else if (m_off) begin
            if (ack) m_off = 0;
        end else if (pd) begin
            m_dec = 1;
        end
        m_dem = (m_dem & ~clr) | set;
        m_deb = dn;
        m_cyc = m_cyc + 1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        ss_ped = 1; cs_ped = 1; ss_str = 1; ss_trn = 1; cs_str = 1; cs_trn = 1;
        u_if.current_phase = 2'd2; u_if.phase_done = 1; u_if.next_phase_ack = 1;
        reset_n = 1'b0;
        cyc(3);
        total++; if (dem !== 4'b0000) begin bad++; $display("FAIL reset_dem got=%b exp=0000", dem); end
        total++; if (spd !== 1'b0) begin bad++; $display("FAIL reset_spd got=%b exp=0", spd); end
        total++; if (alarm !== 1'b0) begin bad++; $display("FAIL reset_alarm got=%b exp=0", alarm); end
        total++; if (u_if.next_phase_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", u_if.next_phase_valid); end
        total++; if (u_if.next_phase !== 2'd0) begin bad++; $display("FAIL reset_np got=%0d exp=0", u_if.next_phase); end
        // reset while an offer is up
        do_reset();
        u_if.phase_done = 1; cyc(1); u_if.phase_done = 0; cyc(1);
        total++; if (u_if.next_phase_valid !== 1'b1) begin bad++; $display("FAIL offer_before_reset got=%b exp=1", u_if.next_phase_valid); end
        reset_n = 1'b0; cyc(1);
        total++; if (u_if.next_phase_valid !== 1'b0) begin bad++; $display("FAIL reset_in_offer got=%b exp=0", u_if.next_phase_valid); end
        reset_n = 1'b1;
    endtask

    task automatic test_debounce();
        do_reset();
        ss_ped = 1; cyc(10); ss_ped = 0; cyc(40);
        total++; if (dem !== 4'b0000) begin bad++; $display("FAIL short_pulse got=%b exp=0000", dem); end
        ss_ped = 1; cyc(21);
        total++; if (dem !== 4'b0000) begin bad++; $display("FAIL deb_edge21 got=%b exp=0000", dem); end
        cyc(1);
        total++; if (dem !== 4'b0001) begin bad++; $display("FAIL deb_edge22 got=%b exp=0001", dem); end
        cyc(8); ss_ped = 0; cyc(30);
        total++; if (dem !== 4'b0001) begin bad++; $display("FAIL btn_latched got=%b exp=0001", dem); end
    endtask

    task automatic test_round_robin();
        do_reset();
        u_if.current_phase = 2'd0;
        ss_trn = 1; cs_trn = 1; cyc(30); ss_trn = 0; cs_trn = 0; cyc(30);
        total++; if (dem !== 4'b1010) begin bad++; $display("FAIL rr_dem got=%b exp=1010", dem); end
        u_if.phase_done = 1; cyc(1); u_if.phase_done = 0;
        total++; if (u_if.next_phase_valid !== 1'b0) begin bad++; $display("FAIL rr_valid_early got=%b exp=0", u_if.next_phase_valid); end
        cyc(1);
        total++; if (u_if.next_phase_valid !== 1'b1) begin bad++; $display("FAIL rr_valid got=%b exp=1", u_if.next_phase_valid); end
        total++; if (u_if.next_phase !== 2'd1) begin bad++; $display("FAIL rr_np got=%0d exp=1", u_if.next_phase); end
        u_if.next_phase_ack = 1; cyc(1); u_if.next_phase_ack = 0;
        total++; if (dem !== 4'b1000) begin bad++; $display("FAIL rr_clear got=%b exp=1000", dem); end
        total++; if (u_if.next_phase_valid !== 1'b0) begin bad++; $display("FAIL rr_valid_drop got=%b exp=0", u_if.next_phase_valid); end
    endtask

    task automatic test_default_hold();
        do_reset();
        u_if.current_phase = 2'd3;
        u_if.phase_done = 1; cyc(1); u_if.phase_done = 0; cyc(1);
        for (int i = 0; i < 50; i++) begin
            total++; if (u_if.next_phase_valid !== 1'b1) begin bad++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", i, u_if.next_phase_valid); end
            total++; if (u_if.next_phase !== 2'd0) begin bad++; $display("FAIL hold_np cyc=%0d got=%0d exp=0", i, u_if.next_phase); end
            cyc(1);
        end
        u_if.next_phase_ack = 1; cyc(1); u_if.next_phase_ack = 0;
        total++; if (u_if.next_phase_valid !== 1'b0) begin bad++; $display("FAIL hold_release got=%b exp=0", u_if.next_phase_valid); end
    endtask

    task automatic test_starvation();
        int n;
        do_reset();
        u_if.current_phase = 2'd0;
        cs_ped = 1; cyc(30); cs_ped = 0; cyc(40);
        ss_trn = 1; cyc(30); ss_trn = 0;
        total++; if (alarm !== 1'b0) begin bad++; $display("FAIL alarm_early got=%b exp=0", alarm); end
        n = 0;
        while (alarm !== 1'b1 && n < 300) begin cyc(1); n++; end
        total++; if (alarm !== 1'b1) begin bad++; $display("FAIL alarm_timeout got=%b exp=1 after %0d cycles", alarm, n); end
        total++; if (dem !== 4'b0110) begin bad++; $display("FAIL starve_dem got=%b exp=0110", dem); end
        u_if.phase_done = 1; cyc(1); u_if.phase_done = 0; cyc(1);
        total++; if (u_if.next_phase !== 2'd2 || u_if.next_phase_valid !== 1'b1) begin bad++; $display("FAIL starve_pick got=%0d/%b exp=2/1", u_if.next_phase, u_if.next_phase_valid); end
        u_if.next_phase_ack = 1; cyc(1); u_if.next_phase_ack = 0;
        total++; if (dem !== 4'b0010) begin bad++; $display("FAIL starve_clear got=%b exp=0010", dem); end
        cyc(2);
        total++; if (alarm !== 1'b0) begin bad++; $display("FAIL alarm_drop got=%b exp=0", alarm); end
    endtask

    task automatic test_speed_up();
        do_reset();
        u_if.current_phase = 2'd0;
        cs_ped = 1; cyc(22);
        total++; if (dem !== 4'b0100) begin bad++; $display("FAIL spd_dem got=%b exp=0100", dem); end
        total++; if (spd !== 1'b0) begin bad++; $display("FAIL spd_early got=%b exp=0", spd); end
        cyc(1);
        total++; if (spd !== 1'b1) begin bad++; $display("FAIL spd_rise got=%b exp=1", spd); end
        cs_str = 1; cyc(25);
        u_if.current_phase = 2'd1;
        u_if.phase_done = 1; cyc(1); u_if.phase_done = 0;
        total++; if (spd !== 1'b1) begin bad++; $display("FAIL spd_hold got=%b exp=1", spd); end
        cyc(1);
        total++; if (spd !== 1'b0) begin bad++; $display("FAIL spd_drop got=%b exp=0", spd); end
        total++; if (u_if.next_phase !== 2'd2 || u_if.next_phase_valid !== 1'b1) begin bad++; $display("FAIL setclr_offer got=%0d/%b exp=2/1", u_if.next_phase, u_if.next_phase_valid); end
        u_if.next_phase_ack = 1; cyc(1); u_if.next_phase_ack = 0;
        total++; if (dem !== 4'b0100) begin bad++; $display("FAIL set_wins got=%b exp=0100", dem); end
        total++; if (u_if.next_phase_valid !== 1'b0) begin bad++; $display("FAIL setclr_valid got=%b exp=0", u_if.next_phase_valid); end
        cs_ped = 0; cs_str = 0;
    endtask

    task automatic test_random();
        logic [5:0] pins;
        do_reset();
        model_reset();
        pins = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 6; i++) begin
                if ($urandom_range(0, 24) == 0) pins[i] = ~pins[i];
            end
            if ($urandom_range(0, 49) == 0) u_if.current_phase = 2'($urandom_range(0, 3));
            u_if.phase_done     = ($urandom_range(0, 14) == 0);
            u_if.next_phase_ack = ($urandom_range(0, 2) == 0);
            ss_ped = pins[0]; cs_ped = pins[1]; ss_str = pins[2];
            ss_trn = pins[3]; cs_str = pins[4]; cs_trn = pins[5];
            @(posedge clk);
            model_step(pins, u_if.current_phase, u_if.phase_done, u_if.next_phase_ack);
            #1;
            total++; if (dem !== m_dem) begin bad++; $display("FAIL rnd_dem cyc=%0d got=%b exp=%b", c, dem, m_dem); end
            total++; if (spd !== m_spd) begin bad++; $display("FAIL rnd_spd cyc=%0d got=%b exp=%b", c, spd, m_spd); end
            total++; if (alarm !== m_alarm) begin bad++; $display("FAIL rnd_alarm cyc=%0d got=%b exp=%b", c, alarm, m_alarm); end
            total++; if (u_if.next_phase_valid !== m_off) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, u_if.next_phase_valid, m_off); end
            if (m_off) begin
                total++; if (u_if.next_phase !== m_np) begin bad++; $display("FAIL rnd_np cyc=%0d got=%0d exp=%0d", c, u_if.next_phase, m_np); end
            end
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_debounce();
        test_round_robin();
        test_default_hold();
        test_starvation();
        test_speed_up();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
